// File: rtl/pfu_fetch_pkg.sv
// Shared prefetch definitions.
// Start-of-fetch-ID codes marking the first word after a redirect.
package pfu_fetch_pkg;

  localparam int SOFID_W = 2;

  typedef enum logic [SOFID_W-1:0] {
    SOFID_RUN = 2'b00,
    SOFID_1ST = 2'b01
  } sofid_e;

endpackage

// File: rtl/pfu_fifo.sv
// Synchronous FIFO with flush, occupancy count, simultaneous push/pop.
// Head is read straight from storage, so a pushed word shows next cycle.
module pfu_fifo #(
  parameter int W  = 8,
  parameter int DX = 2
) (
  input  logic          clk_i,
  input  logic          resetb_i,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic [DX:0]   count_o
);

  localparam int D = 1 << DX;

  logic [W-1:0]  mem_q [D];
  logic [DX-1:0] wp_q, wp_d;
  logic [DX-1:0] rp_q, rp_d;
  logic [DX:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != (DX+1)'(D)) || do_pop);

  // Pointer and count next-state
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk_i) begin
    if (en_i && do_push && !flush_i) mem_q[wp_q] <= data_i;
  end

  assign data_o  = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/pfu_fetch.sv
// Prefetch unit: sequential word fetch into a small FIFO feeding decode.
// Redirects flush the FIFO and discard responses still in flight.
module pfu_fetch
  import pfu_fetch_pkg::*;
#(
  parameter int                C_XLEN         = 32,
  parameter int                C_FIFO_DEPTH_X = 2,
  parameter logic [C_XLEN-1:0] C_RESET_VECTOR = '0
) (
  input  logic               clk_i,
  input  logic               resetb_i,
  input  logic               clk_en_i,
  input  logic               vec_i,
  input  logic [C_XLEN-1:0]  vec_pc_i,
  output logic               ireqvalid_o,
  input  logic               ireqready_i,
  output logic [C_XLEN-1:0]  ireqaddr_o,
  input  logic               irspvalid_i,
  input  logic               irsperror_i,
  input  logic [31:0]        irspdata_i,
  output logic               pfu_dav_o,
  input  logic               pfu_ack_i,
  output logic [SOFID_W-1:0] pfu_sofid_o,
  output logic [31:0]        pfu_ins_o,
  output logic               pfu_ferr_o,
  output logic [C_XLEN-1:0]  pfu_pc_o
);

  localparam int DEPTH = 1 << C_FIFO_DEPTH_X;
  localparam int CW    = C_FIFO_DEPTH_X + 1;
  localparam int EW    = 32 + 1 + C_XLEN + SOFID_W;

  logic [C_XLEN-1:0] reqaddr_q, reqaddr_d;
  logic [C_XLEN-1:0] rsppc_q, rsppc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              first_q, first_d;
  logic              halted_q, halted_d;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_din, fifo_head;
  logic [CW:0]       used;
  logic              req_fire, rsp_keep, pop;
  logic [C_XLEN-1:0] vec_pc;
  sofid_e            sof;
  logic              unused_ok;

  assign unused_ok = ^vec_pc_i[1:0];
  assign vec_pc    = {vec_pc_i[C_XLEN-1:2], 2'b00};

  assign used = {1'b0, out_q} + {1'b0, fifo_cnt};
  assign ireqvalid_o = resetb_i && !halted_q && !vec_i &&
                       (used < (CW+1)'(DEPTH));
  assign ireqaddr_o  = reqaddr_q;

  assign req_fire = ireqvalid_o && ireqready_i;
  assign rsp_keep = irspvalid_i && (drop_q == '0) && !vec_i;
  assign pop      = pfu_dav_o && pfu_ack_i && !vec_i;
  assign sof      = first_q ? SOFID_1ST : SOFID_RUN;
  assign fifo_din = {irspdata_i, irsperror_i, rsppc_q, sof};

  // Credit, drop, PC and redirect next-state
  always_comb begin
    reqaddr_d = reqaddr_q;
    rsppc_d   = rsppc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    first_d   = first_q;
    halted_d  = halted_q;
    unique case ({req_fire, irspvalid_i})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    if (irspvalid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (req_fire) reqaddr_d = reqaddr_q + C_XLEN'(4);
    if (rsp_keep) begin
      rsppc_d = rsppc_q + C_XLEN'(4);
      first_d = 1'b0;
      if (irsperror_i) halted_d = 1'b1;
    end
    if (vec_i) begin
      drop_d    = out_d;
      reqaddr_d = vec_pc;
      rsppc_d   = vec_pc;
      first_d   = 1'b1;
      halted_d  = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      reqaddr_q <= C_RESET_VECTOR;
      rsppc_q   <= C_RESET_VECTOR;
      out_q     <= '0;
      drop_q    <= '0;
      first_q   <= 1'b1;
      halted_q  <= 1'b0;
    end else if (clk_en_i) begin
      reqaddr_q <= reqaddr_d;
      rsppc_q   <= rsppc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      first_q   <= first_d;
      halted_q  <= halted_d;
    end
  end

  pfu_fifo #(
    .W  (EW),
    .DX (C_FIFO_DEPTH_X)
  ) u_fifo (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .en_i     (clk_en_i),
    .flush_i  (vec_i),
    .push_i   (rsp_keep),
    .pop_i    (pop),
    .data_i   (fifo_din),
    .data_o   (fifo_head),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  assign pfu_dav_o = !fifo_empty;
  assign {pfu_ins_o, pfu_ferr_o, pfu_pc_o, pfu_sofid_o} = fifo_head;

endmodule

// File: tb/tb_pfu_fetch.sv
// Bench for pfu_fetch: bus model plus an epoch-tagged stream model.
// Directed scenarios followed by a randomized soak.
module tb_pfu_fetch;

  logic        clk = 1'b0;
  logic        resetb, en, vec, ready, rspv, rsperr, ack;
  logic [31:0] vpc, rspdata;
  logic        ireqvalid, dav, ferr;
  logic [31:0] addr, ins, pc;
  logic [1:0]  sof;

  always #5 clk = ~clk;

  pfu_fetch dut (
    .clk_i       (clk),
    .resetb_i    (resetb),
    .clk_en_i    (en),
    .vec_i       (vec),
    .vec_pc_i    (vpc),
    .ireqvalid_o (ireqvalid),
    .ireqready_i (ready),
    .ireqaddr_o  (addr),
    .irspvalid_i (rspv),
    .irsperror_i (rsperr),
    .irspdata_i  (rspdata),
    .pfu_dav_o   (dav),
    .pfu_ack_i   (ack),
    .pfu_sofid_o (sof),
    .pfu_ins_o   (ins),
    .pfu_ferr_o  (ferr),
    .pfu_pc_o    (pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } bus_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ferr;
    logic [1:0]  sof;
  } exp_t;

  bus_t bq[$];
  exp_t expq[$];

  int checks = 0;
  int errors = 0;
  int epoch = 0;
  int n_acc = 0;
  int pr_ready = 100, pr_rsp = 100, pr_ack = 100, pr_err = 0;
  bit force_ack = 0;
  bit first_m = 1, halted_m = 0;
  logic [31:0] exp_req = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] last_first_pc = 32'hDEAD_BEEF;
  logic [31:0] last_ferr_pc = 32'hDEAD_BEEF;
  bit frz_valid = 0;
  logic        s_valid, s_dav;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetb = 0; en = 1; vec = 0; vpc = 0;
    ready = 0; rspv = 0; rsperr = 0; rspdata = 0; ack = 0;
    @(posedge clk);
    #1;
    chk("rst_reqvalid", ireqvalid, 0);
    chk("rst_dav", dav, 0);
    chk("rst_addr", addr, 32'h0);
    @(negedge clk);
    resetb = 1;
    bq.delete();
    expq.delete();
    epoch++;
    exp_req = 0;
    first_m = 1;
    halted_m = 0;
    n_acc = 0;
  endtask

  task automatic step(input bit v, input logic [31:0] p, input bit e,
                      input int frsp);
    bit r;
    bus_t b;
    exp_t x;
    en = e;
    vec = v && e;
    vpc = p;
    ready = e && ($urandom_range(0, 99) < pr_ready);
    if (frsp < 0) r = ($urandom_range(0, 99) < pr_rsp);
    else r = (frsp != 0);
    rspv = e && r && (bq.size() > 0);
    if (rspv) begin
      rsperr = (bq[0].addr == err_addr) ||
               ($urandom_range(0, 99) < pr_err);
      rspdata = memf(bq[0].addr);
    end else begin
      rsperr = 0;
      rspdata = $urandom;
    end
    ack = force_ack || ($urandom_range(0, 99) < pr_ack);
    #1;
    chk("dav", dav, expq.size() != 0);
    chk("credit_inv", (bq.size() + int'(dut.fifo_cnt)) <= 4, 1);
    if (halted_m || vec) chk("reqvalid_off", ireqvalid, 0);
    if (!e) begin
      if (!frz_valid) begin
        frz_valid = 1;
        s_valid = ireqvalid; s_addr = addr;
        s_dav = dav; s_pc = pc;
      end else begin
        chk("frz_reqvalid", ireqvalid, s_valid);
        chk("frz_addr", addr, s_addr);
        chk("frz_dav", dav, s_dav);
        if (s_dav) chk("frz_pc", pc, s_pc);
      end
    end
    if (e && dav && ack && !vec && expq.size() > 0) begin
      x = expq.pop_front();
      chk("pc", pc, x.pc);
      chk("ins", ins, x.ins);
      chk("ferr", ferr, x.ferr);
      chk("sofid", sof, x.sof);
      if (x.sof == 2'b01) last_first_pc = x.pc;
      if (x.ferr) last_ferr_pc = x.pc;
    end
    if (e && ireqvalid && ready) begin
      chk("reqaddr", addr, exp_req);
      bq.push_back('{addr: exp_req, ep: epoch});
      exp_req += 4;
      n_acc++;
    end
    if (rspv) begin
      b = bq.pop_front();
      if (b.ep == epoch && !vec) begin
        expq.push_back('{pc: b.addr, ins: memf(b.addr), ferr: rsperr,
                         sof: first_m ? 2'b01 : 2'b00});
        first_m = 0;
        if (rsperr) halted_m = 1;
      end
    end
    if (e && vec) begin
      expq.delete();
      epoch++;
      exp_req = {p[31:2], 2'b00};
      first_m = 1;
      halted_m = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, -1);
  endtask

  initial begin
    // sequential stream, consumer always ready
    do_reset();
    run(20);
    chk("stream_first_pc", last_first_pc, 32'h0);

    // consumer stalled: credit limits issue to depth
    do_reset();
    pr_ack = 0;
    run(10);
    chk("stall_reqs", n_acc, 4);
    chk("stall_fifo", expq.size(), 4);
    chk("stall_reqvalid", ireqvalid, 0);
    force_ack = 1;
    run(1);
    force_ack = 0;
    run(5);
    chk("one_ack_one_req", n_acc, 5);
    pr_ack = 100;

    // redirect with three requests in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("inflight3", bq.size(), 3);
    step(1, 32'h1003, 1, 0);
    run(15);
    chk("vec_first_pc", last_first_pc, 32'h1000);

    // redirect coinciding with a response
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(1, 32'h200, 1, 1);
    run(15);
    chk("vec_rsp_first_pc", last_first_pc, 32'h200);

    // bus error halts fetch until redirect
    do_reset();
    err_addr = 32'h8;
    run(12);
    chk("err_pc", last_ferr_pc, 32'h8);
    chk("err_halt", ireqvalid, 0);
    step(1, 32'h40, 1, -1);
    err_addr = 32'hFFFF_FFFF;
    run(12);
    chk("err_resume_pc", last_first_pc, 32'h40);

    // clock-enable freeze, then reset mid-stream
    do_reset();
    pr_rsp = 60;
    run(10);
    frz_valid = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    run(10);
    do_reset();
    run(10);

    // randomized soak
    pr_err = 2;
    for (int i = 0; i < 2500; i++) begin
      if (i % 100 == 0) begin
        pr_ready = $urandom_range(20, 100);
        pr_rsp = $urandom_range(20, 100);
        pr_ack = $urandom_range(20, 100);
      end
      if ($urandom_range(0, 99) < 3) step(1, $urandom, 1, -1);
      else if ($urandom_range(0, 99) < 5) begin
        frz_valid = 0;
        step(0, 0, 0, 0);
      end else step(0, 0, 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
